// File: rtl/fetch_responder.sv
// Two-entry instruction fetch buffer with miss fill and sequential prefetch.
// Ports: clk/reset, fetch_addr -> fetch_data/fetch_ready, fence_i, mem_req/mem_addr/mem_rdata/mem_ack.
module fetch_responder #(
  parameter int unsigned PREFETCH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        fence_i,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [1:0]  valid_q, valid_d;
  logic [29:0] tag_q [2];
  logic [29:0] tag_d [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic        last_q, last_d;
  logic        mem_req_q, mem_req_d;
  logic [29:0] mem_tag_q, mem_tag_d;

  logic [29:0] fa_tag;
  logic [29:0] pf_tag;
  logic [1:0]  hit;
  logic [1:0]  pf_hit;
  logic [1:0]  dup;
  logic        victim;
  logic        unused_lsb;

  assign fa_tag     = fetch_addr[31:2];
  assign pf_tag     = fa_tag + 30'd1;
  assign unused_lsb = ^fetch_addr[1:0];
  assign mem_req    = mem_req_q;
  assign mem_addr   = {mem_tag_q, 2'b00};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit[i]    = valid_q[i] && (tag_q[i] == fa_tag);
      pf_hit[i] = valid_q[i] && (tag_q[i] == pf_tag);
      dup[i]    = valid_q[i] && (tag_q[i] == mem_tag_q);
    end
  end

  always_comb begin
    fetch_ready = |hit;
    fetch_data  = 32'h0;
    if (hit[0]) begin
      fetch_data = data_q[0];
    end else if (hit[1]) begin
      fetch_data = data_q[1];
    end
  end

  // Victim: matching tag, then lowest invalid, then the entry not
  // being fetched from, finally the older of the two installs.
  always_comb begin
    victim = ~last_q;
    if (dup[0]) begin
      victim = 1'b0;
    end else if (dup[1]) begin
      victim = 1'b1;
    end else if (!valid_q[0]) begin
      victim = 1'b0;
    end else if (!valid_q[1]) begin
      victim = 1'b1;
    end else if (hit[0] && !hit[1]) begin
      victim = 1'b1;
    end else if (hit[1] && !hit[0]) begin
      victim = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    last_d    = last_q;
    mem_req_d = mem_req_q;
    mem_tag_d = mem_tag_q;
    unique case (state_q)
      IDLE: begin
        if (!fetch_ready) begin
          state_d   = WAIT;
          mem_req_d = 1'b1;
          mem_tag_d = fa_tag;
        end else if (PREFETCH != 0 && pf_hit == 2'b00) begin
          state_d   = WAIT;
          mem_req_d = 1'b1;
          mem_tag_d = pf_tag;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (!drop_q && !fence_i) begin
            valid_d[victim] = 1'b1;
            tag_d[victim]   = mem_tag_q;
            data_d[victim]  = mem_rdata;
            last_d          = victim;
          end
        end else if (fence_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fence_i) begin
      valid_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      valid_q   <= 2'b00;
      tag_q     <= '{default: '0};
      data_q    <= '{default: '0};
      last_q    <= 1'b0;
      mem_req_q <= 1'b0;
      mem_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      last_q    <= last_d;
      mem_req_q <= mem_req_d;
      mem_tag_q <= mem_tag_d;
    end
  end

endmodule

// File: tb/tb_fetch_responder.sv
// Testbench for fetch_responder: directed scenarios plus random traffic
// checked every cycle against a behavioural buffer model.
module tb_fetch_responder;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        fence_i;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  fetch_responder #(.PREFETCH(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_ready(fetch_ready),
    .fence_i    (fence_i),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  bit          m_val [2];
  logic [29:0] m_tag [2];
  logic [31:0] m_dat [2];
  int          m_ts  [2];
  int          ts_ctr;
  bit          m_pend;
  bit          m_drop;
  logic [31:0] m_addr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if (m_val[i] && m_tag[i] == a[31:2]) return i;
    return -1;
  endfunction

  task automatic m_install(input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] fa);
    int idx;
    int h;
    idx = find(a);
    if (idx < 0) begin
      for (int i = 1; i >= 0; i--)
        if (!m_val[i]) idx = i;
    end
    if (idx < 0) begin
      h = find(fa);
      if (h >= 0) idx = 1 - h;
      else idx = (m_ts[0] < m_ts[1]) ? 0 : 1;
    end
    ts_ctr++;
    m_val[idx] = 1;
    m_tag[idx] = a[31:2];
    m_dat[idx] = d;
    m_ts[idx]  = ts_ctr;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0;
      m_tag[i] = '0;
      m_dat[i] = '0;
      m_ts[i]  = 0;
    end
    ts_ctr = 0;
    m_pend = 0;
    m_drop = 0;
    m_addr = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] word;
    logic [31:0] nxt;
    if (reset) begin
      m_reset();
    end else begin
      word = fetch_addr & 32'hFFFF_FFFC;
      nxt  = word + 32'd4;
      if (m_pend) begin
        if (mem_ack) begin
          if (!m_drop && !fence_i) m_install(m_addr, mem_rdata, fetch_addr);
          m_pend = 0;
          m_drop = 0;
        end else if (fence_i) begin
          m_drop = 1;
        end
      end else if (find(fetch_addr) < 0) begin
        m_pend = 1;
        m_addr = word;
      end else if (find(nxt) < 0) begin
        m_pend = 1;
        m_addr = nxt;
      end
      if (fence_i) begin
        m_val[0] = 0;
        m_val[1] = 0;
      end
    end
  endtask

  task automatic compare();
    int h;
    h = find(fetch_addr);
    chk("fetch_ready", fetch_ready, (h >= 0) ? 32'd1 : 32'd0);
    chk("fetch_data", fetch_data, (h >= 0) ? m_dat[h] : 32'h0);
    chk("mem_req", mem_req, m_pend ? 32'd1 : 32'd0);
    if (m_pend) chk("mem_addr", mem_addr, m_addr);
  endtask

  task automatic drive(input logic r, input logic f, input logic a,
                       input logic [31:0] rd, input logic [31:0] fa);
    reset      = r;
    fence_i    = f;
    mem_ack    = a;
    mem_rdata  = rd;
    fetch_addr = fa;
    #1;
    if (cmp_en) compare();
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  logic [31:0] pool [8];
  logic [31:0] cur_fa;

  initial begin
    pool[0] = 32'h0000_0100;
    pool[1] = 32'h0000_0104;
    pool[2] = 32'h0000_0108;
    pool[3] = 32'h0000_010C;
    pool[4] = 32'h0000_0200;
    pool[5] = 32'hFFFF_FFF8;
    pool[6] = 32'hFFFF_FFFC;
    pool[7] = 32'h0000_0000;
    m_reset();
    reset = 1; fence_i = 0; mem_ack = 0; mem_rdata = 0; fetch_addr = 0;
    @(negedge clk);
    drive(1, 0, 0, 0, 32'h100); tick();
    drive(1, 0, 0, 0, 32'h100); tick();
    cmp_en = 1;

    // cold miss, then prefetch, then replacement
    drive(0, 0, 0, 0, 32'h100);
    chk("rst_ready", fetch_ready, 0);
    chk("rst_data", fetch_data, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    tick();
    drive(0, 0, 0, 0, 32'h100);
    chk("cold_req", mem_req, 1);
    chk("cold_addr", mem_addr, 32'h100);
    tick();
    drive(0, 0, 0, 0, 32'h100); tick();
    drive(0, 0, 1, 32'h0050_0093, 32'h100); tick();
    drive(0, 0, 0, 0, 32'h100);
    chk("cold_ready", fetch_ready, 1);
    chk("cold_data", fetch_data, 32'h0050_0093);
    chk("cold_req_drop", mem_req, 0);
    tick();
    drive(0, 0, 0, 0, 32'h100);
    chk("pf_req", mem_req, 1);
    chk("pf_addr", mem_addr, 32'h104);
    tick();
    drive(0, 0, 1, 32'h00A0_0113, 32'h100); tick();
    drive(0, 0, 0, 0, 32'h104);
    chk("pf_ready", fetch_ready, 1);
    chk("pf_data", fetch_data, 32'h00A0_0113);
    tick();
    drive(0, 0, 0, 0, 32'h104);
    chk("pf2_addr", mem_addr, 32'h108);
    tick();
    drive(0, 0, 1, 32'h0C00_0193, 32'h104); tick();
    drive(0, 0, 0, 0, 32'h108);
    chk("repl_new", fetch_data, 32'h0C00_0193);
    drive(0, 0, 0, 0, 32'h104);
    chk("repl_kept", fetch_ready, 1);
    drive(0, 0, 0, 0, 32'h100);
    chk("repl_evicted", fetch_ready, 0);
    tick();

    // redirect during WAIT
    drive(1, 0, 0, 0, 32'h200); tick();
    drive(0, 0, 0, 0, 32'h200); tick();
    drive(0, 0, 0, 0, 32'h800);
    chk("redir_addr", mem_addr, 32'h200);
    tick();
    drive(0, 0, 1, 32'h11, 32'h800); tick();
    drive(0, 0, 0, 0, 32'h800);
    chk("redir_gap", mem_req, 0);
    tick();
    drive(0, 0, 0, 0, 32'h800);
    chk("redir_req", mem_req, 1);
    chk("redir_addr2", mem_addr, 32'h800);
    drive(0, 0, 0, 0, 32'h200);
    chk("redir_inst", fetch_data, 32'h11);
    tick();

    // fence during WAIT
    drive(1, 0, 0, 0, 32'h300); tick();
    drive(0, 0, 0, 0, 32'h300); tick();
    drive(0, 1, 0, 0, 32'h300);
    chk("fence_addr", mem_addr, 32'h300);
    tick();
    drive(0, 0, 0, 0, 32'h300); tick();
    drive(0, 0, 1, 32'h33, 32'h300); tick();
    drive(0, 0, 0, 0, 32'h300);
    chk("fence_drop", fetch_ready, 0);
    chk("fence_req0", mem_req, 0);
    tick();
    drive(0, 0, 0, 0, 32'h300);
    chk("fence_rereq", mem_req, 1);
    chk("fence_readdr", mem_addr, 32'h300);
    tick();

    // reset mid-request, late ack ignored
    drive(1, 0, 0, 0, 32'h400); tick();
    drive(0, 0, 0, 0, 32'h400); tick();
    drive(1, 0, 0, 0, 32'h400); tick();
    drive(0, 0, 1, 32'h44, 32'h0);
    chk("rstw_req", mem_req, 0);
    chk("rstw_addr", mem_addr, 0);
    chk("rstw_ready", fetch_ready, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0);
    chk("rstw_miss0", mem_req, 1);
    chk("rstw_addr0", mem_addr, 32'h0);
    drive(0, 0, 0, 0, 32'h400);
    chk("rstw_noinst", fetch_ready, 0);
    tick();

    // prefetch wrap
    drive(1, 0, 0, 0, 32'hFFFF_FFFC); tick();
    drive(0, 0, 0, 0, 32'hFFFF_FFFC); tick();
    drive(0, 0, 1, 32'h55, 32'hFFFF_FFFC); tick();
    drive(0, 0, 0, 0, 32'hFFFF_FFFC);
    chk("wrap_ready", fetch_ready, 1);
    tick();
    drive(0, 0, 0, 0, 32'hFFFF_FFFC);
    chk("wrap_req", mem_req, 1);
    chk("wrap_addr", mem_addr, 32'h0);
    tick();

    // random traffic
    drive(1, 0, 0, 0, 32'h0); tick();
    cur_fa = pool[0];
    for (int n = 0; n < 3000; n++) begin
      logic r, f, a;
      if ($urandom_range(0, 2) == 0)
        cur_fa = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      r = ($urandom_range(0, 149) == 0);
      f = ($urandom_range(0, 24) == 0);
      a = m_pend && ($urandom_range(0, 2) == 0);
      drive(r, f, a, $urandom, cur_fa);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
